xor_stream_decrypt: RTL and testbench
=====================================

# xor_stream_decrypt

Receive-side decryption engine for the 8-bit cryptosystem. It accepts ciphertext bytes over a valid/ready stream and XORs each one with a keystream byte from an 8-bit Galois LFSR seeded by the shared key. It returns plaintext on a registered valid/ready output. It is the counterpart of the transmit-side encryptor: given the same key and taps, decrypt(encrypt(p)) == p byte for byte.

## Interface
Parameters:
- TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1).
- CNT_W, 16, width of the processed-byte counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_load  in  1  one-cycle strobe that loads the key and restarts the keystream.
- key  in  8  seed sampled when key_load=1.
- in_valid  in  1  ciphertext byte present.
- in_ready  out  1  block can accept a ciphertext byte this cycle.
- in_data  in  8  ciphertext byte.
- out_valid  out  1  plaintext byte held in the output register.
- out_ready  in  1  downstream accepts the plaintext byte.
- out_data  out  8  plaintext byte.
- keyed  out  1  a key has been loaded since reset.
- byte_count  out  CNT_W  number of bytes accepted since the last key load.

## Operation
- State machine has two states.
  - UNKEYED: entered at reset. in_ready=0. Moves to KEYED on key_load.
  - KEYED: stays here until rst. A key_load in KEYED reseeds the LFSR.
- Seed rule: lfsr <= (key==8'h00) ? 8'h01 : key. This avoids LFSR lock-up.
- Keystream byte = current lfsr value.
- Step rule: lfsr <= lfsr[0] ? ((lfsr>>1) ^ TAPS) : (lfsr>>1).
- Accept condition: in_valid && in_ready. On accept:
  - out_data <= in_data ^ lfsr
  - out_valid <= 1
  - LFSR steps once
  - byte_count increments
- in_ready = keyed && !key_load && (!out_valid || out_ready). The single output register therefore refills in the same cycle it drains.
- Output handshake: out_valid && out_ready && no new accept -> out_valid <= 0. out_data holds steady while out_valid=1 and out_ready=0.
- key_load effects:
  - Takes priority over input: no byte is accepted in that cycle.
  - byte_count <= 0.
  - A pending output byte is retained (it was decrypted under the old key).
- byte_count wraps modulo 2^CNT_W, with no saturation or flag.
- in_data is ignored when in_valid=0, and the LFSR does not step.

## Timing
- Reset values: out_valid=0, out_data=8'h00, in_ready=0, keyed=0, byte_count=0, lfsr=8'h01.
- rst asserted mid-stream clears everything on the next edge. Any pending output byte is dropped and the block returns to UNKEYED.
- Latency: 1 cycle from accepted in_data to out_data/out_valid.
- Throughput: 1 byte per cycle while out_ready=1.
- in_ready is combinational from out_valid, out_ready, keyed and key_load. There is no combinational path from in_data to out_data.
- First accept is possible in the cycle after key_load.
- Simultaneous out drain and in accept: out_valid stays 1 and out_data takes the new byte.

## Structure
- Shared package `crypto_pkg` holds:
  - BYTE_W=8
  - the default LFSR taps constant
  - the zero-key substitute constant 8'h01

  The encryptor imports the same package so both ends' keystreams are identical.
- One natural sub-module: `keystream_lfsr`, with ports clk, rst, load, seed, step, ks. It is reused unchanged by the encryptor. The XOR, output register, FSM and counter stay in the top level.

## Test plan
- Reset, then in_valid=1 with no key_load: in_ready=0, out_valid stays 0, byte_count=0.
- key=8'h5A loaded, then three 8'hFF bytes at full rate with out_ready=1: outputs A5, D2, 51 on consecutive cycles, byte_count=3.
- key=8'h00 loaded, then bytes 00, 00: outputs 01, B8 (zero-key substitution).
- Backpressure: out_ready=0 after the first output. in_ready falls and out_data holds A5 until out_ready=1, after which D2 follows and no byte is lost or duplicated.
- key_load asserted in the same cycle as in_valid: that byte is not accepted and the pending output is retained. The next byte decrypts with the new seed and byte_count restarts from 0.
- Loopback: a random 256-byte stream is encrypted by the encryptor model with the same key and fed through the block. The output equals the original plaintext, byte_count wraps correctly with CNT_W=8, and rst asserted mid-stream yields out_valid=0 and keyed=0 on the next cycle.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared constants and keystream helpers for the 8-bit XOR stream cryptosystem.
// Imported by both the encryptor and the decryptor so their keystreams match.
package crypto_pkg;

  localparam int         BYTE_W       = 8;
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] ZERO_KEY_SUB = 8'h01;

  typedef enum logic {
    UNKEYED = 1'b0,
    KEYED   = 1'b1
  } key_state_e;

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [BYTE_W-1:0] lfsr_seed(input logic [BYTE_W-1:0] key);
    return (key == 8'h00) ? ZERO_KEY_SUB : key;
  endfunction

  function automatic logic [BYTE_W-1:0] lfsr_next(input logic [BYTE_W-1:0] cur,
                                                  input logic [BYTE_W-1:0] taps);
    return cur[0] ? ((cur >> 1) ^ taps) : (cur >> 1);
  endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 8-bit Galois LFSR keystream generator; the current state is the keystream byte.
// Shared unchanged between the encrypt and decrypt ends.
module keystream_lfsr
  import crypto_pkg::*;
#(
  parameter logic [BYTE_W-1:0] TAPS = LFSR_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] seed,
  input  logic              step,
  output logic [BYTE_W-1:0] ks
);

  logic [BYTE_W-1:0] lfsr_r;

  // Seed on load (load wins over step), otherwise advance once per consumed byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= ZERO_KEY_SUB;
    end else if (load) begin
      lfsr_r <= lfsr_seed(seed);
    end else if (step) begin
      lfsr_r <= lfsr_next(lfsr_r, TAPS);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign ks = lfsr_r;

endmodule

// File: rtl/xor_stream_decrypt.sv
// Receive-side decryptor: XORs accepted ciphertext bytes with the LFSR keystream
// and presents plaintext from a single registered valid/ready output stage.
module xor_stream_decrypt
  import crypto_pkg::*;
#(
  parameter logic [BYTE_W-1:0] TAPS  = LFSR_TAPS,
  parameter int                CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [BYTE_W-1:0] key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              keyed,
  output logic [CNT_W-1:0]  byte_count
);

  key_state_e        state_r;
  logic              out_valid_r;
  logic [BYTE_W-1:0] out_data_r;
  logic [CNT_W-1:0]  byte_count_r;
  logic [BYTE_W-1:0] ks_s;
  logic              in_ready_s;
  logic              accept_s;

  // key_load blocks input so a byte is never split across two keys.
  assign in_ready_s = (state_r == KEYED) && !key_load && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;

  keystream_lfsr #(.TAPS(TAPS)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (key_load),
    .seed (key),
    .step (accept_s),
    .ks   (ks_s)
  );

  // Key FSM, byte counter and output register; a pending byte survives a rekey.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= UNKEYED;
      out_valid_r  <= 1'b0;
      out_data_r   <= 8'h00;
      byte_count_r <= '0;
    end else begin
      case (state_r)
        UNKEYED: state_r <= key_load ? KEYED : UNKEYED;
        KEYED:   state_r <= KEYED;
        default: state_r <= UNKEYED;
      endcase

      if (key_load) begin
        byte_count_r <= '0;
      end else if (accept_s) begin
        byte_count_r <= byte_count_r + CNT_W'(1);
      end else begin
        byte_count_r <= byte_count_r;
      end

      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= in_data ^ ks_s;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
        out_data_r  <= out_data_r;
      end else begin
        out_valid_r <= out_valid_r;
        out_data_r  <= out_data_r;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign keyed      = (state_r == KEYED);
  assign byte_count = byte_count_r;

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Self-checking bench for xor_stream_decrypt: directed keystream vectors plus a
// randomized 256-byte encrypt/decrypt loopback with random backpressure.
module tb_xor_stream_decrypt;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_load;
  logic [7:0]       key;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             keyed;
  logic [CNT_W-1:0] byte_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pt [256];
  logic [7:0] ct [256];

  always #5 clk = ~clk;

  xor_stream_decrypt #(.TAPS(8'hB8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .key        (key),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .keyed      (keyed),
    .byte_count (byte_count)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encryptor: keystream byte i is the seed advanced i times.
  task automatic encrypt_stream(input logic [7:0] k);
    logic [7:0] s;
    s = (k == 8'h00) ? 8'h01 : k;
    for (int i = 0; i < 256; i++) begin
      ct[i] = pt[i] ^ s;
      s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    end
  endtask

  task automatic load_key(input logic [7:0] k);
    key_load = 1'b1;
    key      = k;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    int sent;
    int rcv;
    int cyc;
    logic [7:0] rkey;

    rst = 1'b1; key_load = 1'b0; key = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_out_valid", 16'(out_valid), 16'h0);
    check_eq("rst_out_data", 16'(out_data), 16'h00);
    check_eq("rst_in_ready", 16'(in_ready), 16'h0);
    check_eq("rst_keyed", 16'(keyed), 16'h0);
    check_eq("rst_count", 16'(byte_count), 16'h0);

    // Unkeyed: input must be refused.
    in_valid = 1'b1; in_data = 8'hAA;
    #1 check_eq("unkeyed_ready", 16'(in_ready), 16'h0);
    tick();
    check_eq("unkeyed_valid", 16'(out_valid), 16'h0);
    check_eq("unkeyed_count", 16'(byte_count), 16'h0);
    in_valid = 1'b0;

    // Known vectors for key 5A at full rate.
    load_key(8'h5A);
    check_eq("keyed", 16'(keyed), 16'h1);
    in_valid = 1'b1; in_data = 8'hFF;
    tick(); check_eq("k5a_b0", 16'(out_data), 16'hA5); check_eq("k5a_v0", 16'(out_valid), 16'h1);
    tick(); check_eq("k5a_b1", 16'(out_data), 16'hD2);
    tick(); check_eq("k5a_b2", 16'(out_data), 16'h51);
    check_eq("k5a_count", 16'(byte_count), 16'h3);
    in_valid = 1'b0;
    tick(); check_eq("k5a_drain", 16'(out_valid), 16'h0);

    // Zero key substitutes seed 01.
    load_key(8'h00);
    in_valid = 1'b1; in_data = 8'h00;
    tick(); check_eq("k00_b0", 16'(out_data), 16'h01);
    tick(); check_eq("k00_b1", 16'(out_data), 16'hB8);
    in_valid = 1'b0;
    tick();

    // Backpressure holds the output byte.
    load_key(8'h5A);
    in_valid = 1'b1; in_data = 8'hFF;
    tick(); check_eq("bp_first", 16'(out_data), 16'hA5);
    out_ready = 1'b0;
    #1 check_eq("bp_ready_low", 16'(in_ready), 16'h0);
    tick(); check_eq("bp_hold0", 16'(out_data), 16'hA5); check_eq("bp_hold_v", 16'(out_valid), 16'h1);
    tick(); check_eq("bp_hold1", 16'(out_data), 16'hA5);
    out_ready = 1'b1;
    #1 check_eq("bp_ready_high", 16'(in_ready), 16'h1);
    tick(); check_eq("bp_next", 16'(out_data), 16'hD2); check_eq("bp_next_v", 16'(out_valid), 16'h1);
    in_valid = 1'b0;
    tick(); check_eq("bp_empty", 16'(out_valid), 16'h0);
    check_eq("bp_count", 16'(byte_count), 16'h2);

    // key_load in the same cycle as in_valid: byte refused, pending output kept.
    load_key(8'h5A);
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
    tick(); check_eq("kl_pending", 16'(out_data), 16'hA5);
    key_load = 1'b1; key = 8'h00; in_data = 8'h33;
    #1 check_eq("kl_ready", 16'(in_ready), 16'h0);
    tick();
    key_load = 1'b0;
    check_eq("kl_kept_data", 16'(out_data), 16'hA5);
    check_eq("kl_kept_valid", 16'(out_valid), 16'h1);
    check_eq("kl_count_clr", 16'(byte_count), 16'h0);
    out_ready = 1'b1; in_data = 8'h00;
    tick(); check_eq("kl_newseed", 16'(out_data), 16'h01);
    check_eq("kl_count1", 16'(byte_count), 16'h1);
    in_valid = 1'b0;
    tick();

    // Random loopback with random valid/ready.
    rkey = 8'($urandom);
    for (int i = 0; i < 256; i++) pt[i] = 8'($urandom);
    encrypt_stream(rkey);
    load_key(rkey);
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 256 && cyc < 4000) begin
      in_valid  = (sent < 256) && ($urandom_range(3) != 0);
      in_data   = (sent < 256) ? ct[sent] : 8'h00;
      out_ready = ($urandom_range(3) != 0);
      #1;
      check_eq("lb_ready", 16'(in_ready), 16'((sent == rcv) || out_ready));
      if (out_valid && out_ready) begin
        check_eq($sformatf("lb_pt%0d", rcv), 16'(out_data), 16'(pt[rcv]));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      check_eq("lb_count", 16'(byte_count), 16'(sent % 256));
      cyc++;
    end
    check_eq("lb_timeout", 16'(rcv), 16'd256);
    check_eq("lb_wrap", 16'(byte_count), 16'h0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Mid-stream reset drops the pending byte and unkeys.
    load_key(8'h77);
    in_valid = 1'b1; in_data = 8'h12; out_ready = 1'b0;
    tick();
    check_eq("mr_pending", 16'(out_valid), 16'h1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("mr_valid", 16'(out_valid), 16'h0);
    check_eq("mr_keyed", 16'(keyed), 16'h0);
    check_eq("mr_ready", 16'(in_ready), 16'h0);
    check_eq("mr_count", 16'(byte_count), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
